// File: rtl/snn_sched_pkg.sv
// Shared types and defaults for the SNN batch scheduler.
package snn_sched_pkg;

    localparam int IMG_W_DEF = 10;
    localparam int EP_W_DEF  = 4;
    localparam int TMO_W_DEF = 20;

    localparam logic MODE_LERN = 1'b0;
    localparam logic MODE_INFR = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_INIT_WAIT,
        ST_LOAD,
        ST_FIRE,
        ST_RUN,
        ST_RESULT,
        ST_SETTLE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/snn_sched_wdog.sv
// Run watchdog: clearable, loadable up-counter with a terminal-count flag.
module snn_sched_wdog
    import snn_sched_pkg::*;
#(
    parameter int               TMO_W  = TMO_W_DEF,
    parameter logic [TMO_W-1:0] TC_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [TMO_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [TMO_W-1:0] cnt;

    // Clear wins over load, load wins over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/snn_batch_sched.sv
// Batch scheduler: drives the SNN core over images x epochs and streams winners.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | waiting for start; configuration latched on start
// INIT       | one-cycle core init pulse
// INIT_WAIT  | waiting for core idle after init
// LOAD       | image request to host, waiting for ack
// FIRE       | one-cycle learn/infer pulse, watchdog cleared
// RUN        | waiting for core done, watchdog counting
// RESULT     | result held valid until consumer ready
// SETTLE     | waiting for core to drop done and return idle, then advance
// DONE       | one-cycle batch completion pulse
module snn_batch_sched
    import snn_sched_pkg::*;
#(
    parameter int               IMG_W   = IMG_W_DEF,
    parameter int               EP_W    = EP_W_DEF,
    parameter int               TMO_W   = TMO_W_DEF,
    parameter logic [TMO_W-1:0] TMO_MAX = 20'hFFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic             i_init_en,
    input  logic [IMG_W-1:0] i_num_img,
    input  logic [EP_W-1:0]  i_num_epoch,
    input  logic             i_abort,
    output logic             o_img_req,
    output logic [IMG_W-1:0] o_img_idx,
    input  logic             i_img_ack,
    output logic             o_snn_init,
    output logic             o_snn_lern,
    output logic             o_snn_infr,
    input  logic             i_snn_idle,
    input  logic             i_snn_done,
    input  logic [7:0]       i_snn_winner,
    output logic             o_res_valid,
    output logic [IMG_W-1:0] o_res_idx,
    output logic [EP_W-1:0]  o_res_epoch,
    output logic [7:0]       o_res_winner,
    input  logic             i_res_ready,
    output logic             o_busy,
    output logic             o_batch_done,
    output logic             o_err_tmo
);

    localparam logic [TMO_W-1:0] TMO_TC = TMO_MAX - TMO_W'(1);

    state_t           state, state_nxt;
    logic             mode_q;
    logic [IMG_W-1:0] num_img_q, img_cnt;
    logic [EP_W-1:0]  num_epoch_q, epoch_cnt;
    logic [7:0]       winner_q;
    logic             err_tmo_q;
    logic             start_acc, cap_win, tmo_hit, adv;
    logic             wdog_clr, wdog_en, wdog_tc;
    logic             last_img, last_ep;

    assign last_img = (img_cnt == num_img_q - IMG_W'(1));
    assign last_ep  = (epoch_cnt == num_epoch_q - EP_W'(1));

    snn_sched_wdog #(
        .TMO_W  (TMO_W),
        .TC_VAL (TMO_TC)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (wdog_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (wdog_en),
        .tc       (wdog_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, datapath strobes and state-decoded outputs; abort overrides everything outside IDLE.
    always_comb begin
        state_nxt    = state;
        start_acc    = 1'b0;
        cap_win      = 1'b0;
        tmo_hit      = 1'b0;
        adv          = 1'b0;
        wdog_clr     = 1'b0;
        wdog_en      = 1'b0;
        o_img_req    = 1'b0;
        o_snn_init   = 1'b0;
        o_snn_lern   = 1'b0;
        o_snn_infr   = 1'b0;
        o_res_valid  = 1'b0;
        o_batch_done = 1'b0;

        if (state != ST_IDLE && i_abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start && !i_abort) begin
                        start_acc = 1'b1;
                        if (i_num_img == '0)  state_nxt = ST_DONE;
                        else if (i_init_en)   state_nxt = ST_INIT;
                        else                  state_nxt = ST_LOAD;
                    end
                end
                ST_INIT:      state_nxt = ST_INIT_WAIT;
                ST_INIT_WAIT: if (i_snn_idle) state_nxt = ST_LOAD;
                ST_LOAD:      if (i_img_ack)  state_nxt = ST_FIRE;
                ST_FIRE: begin
                    wdog_clr  = 1'b1;
                    state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    wdog_en = 1'b1;
                    if (i_snn_done) begin
                        cap_win   = 1'b1;
                        state_nxt = ST_RESULT;
                    end else if (wdog_tc) begin
                        tmo_hit   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_RESULT:    if (i_res_ready) state_nxt = ST_SETTLE;
                ST_SETTLE: begin
                    if (!i_snn_done && i_snn_idle) begin
                        adv       = 1'b1;
                        state_nxt = (last_img && last_ep) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_DONE:      state_nxt = ST_IDLE;
                default:      state_nxt = ST_IDLE;
            endcase
        end

        case (state)
            ST_INIT:   o_snn_init   = 1'b1;
            ST_LOAD:   o_img_req    = 1'b1;
            ST_FIRE: begin
                o_snn_lern = (mode_q == MODE_LERN);
                o_snn_infr = (mode_q == MODE_INFR);
            end
            ST_RESULT: o_res_valid  = 1'b1;
            ST_DONE:   o_batch_done = 1'b1;
            default: ;
        endcase
    end

    // Latched configuration, image/epoch counters, captured winner and sticky timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_LERN;
            num_img_q   <= '0;
            num_epoch_q <= '0;
            img_cnt     <= '0;
            epoch_cnt   <= '0;
            winner_q    <= '0;
            err_tmo_q   <= 1'b0;
        end else begin
            if (start_acc) begin
                mode_q      <= i_mode;
                num_img_q   <= i_num_img;
                num_epoch_q <= (i_num_epoch == '0) ? EP_W'(1) : i_num_epoch;
                img_cnt     <= '0;
                epoch_cnt   <= '0;
                err_tmo_q   <= 1'b0;
            end
            if (tmo_hit) err_tmo_q <= 1'b1;
            if (cap_win) winner_q  <= i_snn_winner;
            if (adv) begin
                if (last_img) begin
                    img_cnt   <= '0;
                    epoch_cnt <= epoch_cnt + EP_W'(1);
                end else begin
                    img_cnt   <= img_cnt + IMG_W'(1);
                end
            end
        end
    end

    assign o_img_idx    = img_cnt;
    assign o_res_idx    = img_cnt;
    assign o_res_epoch  = epoch_cnt;
    assign o_res_winner = winner_q;
    assign o_err_tmo    = err_tmo_q;
    assign o_busy       = (state != ST_IDLE);

endmodule
